// File: rtl/bike_pkg.sv
// Shared odometer definitions: reed FSM states and default datapath sizing
// used by the reed sequencer, the distance block and the speed unit.
package bike_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        FIRST   = 2'd1,
        MOVING  = 2'd2
    } reed_state_t;

    localparam int DEF_PERIOD_W        = 16;
    localparam int DEF_TIMEOUT         = 50000;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/reed_debounce.sv
// Reed-switch conditioning: two-flop synchroniser, stability debounce and a
// one-cycle pulse on each accepted 0->1 transition of the filtered level.
module reed_debounce
    import bike_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic reed,
    output logic ev
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          reed_s;
    logic          filt;
    logic [CW-1:0] cnt;

    assign reed_s = sync[1];

    // filt flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            filt <= 1'b0;
            cnt  <= '0;
            ev   <= 1'b0;
        end else begin
            sync <= {sync[0], reed};
            ev   <= 1'b0;
            if (reed_s == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                filt <= reed_s;
                cnt  <= '0;
                ev   <= reed_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reed_sequencer.sv
// Odometer front end: one tick per revolution, revolution period measurement
// handed to the speed unit, moving/stopped tracking and trip-clear sequencing.
module reed_sequencer
    import bike_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PERIOD_W        = DEF_PERIOD_W,
    parameter int TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reed,
    input  logic                enable,
    input  logic                clear,
    output logic                tick,
    output logic                clear_dist,
    output logic [PERIOD_W-1:0] period,
    output logic                period_req,
    input  logic                period_ack,
    output logic                overrun,
    output logic                moving,
    output reed_state_t         fsm_state
);

    localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0] TO_MAX  = PERIOD_W'(TIMEOUT);

    reed_state_t         state, state_next;
    logic                ev;
    logic [PERIOD_W-1:0] cnt;
    logic                produce, stop_enter;
    logic                clear_q, clear_rise;

    reed_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock (clock),
        .reset (reset),
        .reed  (reed),
        .ev    (ev)
    );

    assign fsm_state  = state;
    assign clear_rise = clear & ~clear_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= STOPPED;
        else        state <= state_next;
    end

    // a revolution event outranks a timeout landing in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            STOPPED: if (ev) state_next = FIRST;
            FIRST, MOVING: begin
                if (ev)                  state_next = MOVING;
                else if (cnt == TO_LAST) state_next = STOPPED;
            end
            default: state_next = STOPPED;
        endcase
    end

    always_comb begin
        produce    = 1'b0;
        stop_enter = 1'b0;
        case (state)
            FIRST, MOVING: begin
                produce    = ev;
                stop_enter = (state_next == STOPPED);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (ev || state_next == STOPPED) begin
            cnt <= '0;
        end else if (cnt != TO_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // period_req is a level valid; period_ack sampled high consumes it, and a
    // fresh period arriving while req is high and unacked raises overrun
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick       <= 1'b0;
            moving     <= 1'b0;
            period     <= '0;
            period_req <= 1'b0;
            overrun    <= 1'b0;
            clear_q    <= 1'b0;
            clear_dist <= 1'b0;
        end else begin
            tick       <= ev & enable;
            moving     <= (state_next != STOPPED);
            clear_q    <= clear;
            clear_dist <= clear_rise;
            overrun    <= (overrun & ~clear_rise) | (produce & period_req & ~period_ack);
            if (produce) begin
                period     <= cnt + 1'b1;
                period_req <= 1'b1;
            end else if (stop_enter) begin
                period     <= '0;
                period_req <= 1'b0;
            end else if (period_ack) begin
                period_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reed_sequencer.sv
// Scoreboard bench for reed_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT=100.
module tb_reed_sequencer;
    import bike_pkg::*;

    localparam int DEB = 4;
    localparam int PW  = 16;
    localparam int TO  = 100;
    localparam int LAT = DEB + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          reed = 1'b0;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic          period_ack = 1'b0;
    logic          tick, clear_dist, period_req, overrun, moving;
    logic [PW-1:0] period;
    reed_state_t   fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_c0  = 0;
    bit active   = 1'b0;

    typedef struct {
        int            cyc;
        logic          en;
        logic          has_p;
        logic [PW-1:0] per;
    } ev_exp_t;

    ev_exp_t exp_q[$];

    reed_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .PERIOD_W(PW),
        .TIMEOUT(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .reed       (reed),
        .enable     (enable),
        .clear      (clear),
        .tick       (tick),
        .clear_dist (clear_dist),
        .period     (period),
        .period_req (period_req),
        .period_ack (period_ack),
        .overrun    (overrun),
        .moving     (moving),
        .fsm_state  (fsm_state)
    );

    // clock and edge counter: after rising edge k, cyc == k
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // drive a clean pulse whose first sampled-high edge is c0 and queue the
    // tick/period outcome predicted from the spacing to the previous pulse
    task automatic start_rev(input int c0, input int len);
        ev_exp_t e;
        wait_neg(c0 - 1);
        e.cyc   = c0 + LAT;
        e.en    = enable;
        e.has_p = active && ((c0 - last_c0) <= TO);
        e.per   = PW'(c0 - last_c0);
        exp_q.push_back(e);
        last_c0 = c0;
        active  = 1'b1;
        reed    = 1'b1;
        repeat (len) @(negedge clock);
        reed = 1'b0;
    endtask

    task automatic ack_pulse();
        period_ack = 1'b1;
        @(negedge clock);
        period_ack = 1'b0;
    endtask

    always @(negedge clock) begin : monitor
        ev_exp_t e;
        if (exp_q.size() > 0 && cyc == exp_q[0].cyc) begin
            e = exp_q.pop_front();
            check("tick", 32'(tick), 32'(e.en));
            check("period", 32'(period), e.has_p ? 32'(e.per) : 32'd0);
            check("period_req", 32'(period_req), 32'(e.has_p));
        end else if (tick) begin
            check("tick_spurious", 32'(tick), 32'd0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        #2 reset = 1'b0;
        wait_neg(3);
        check("rst_outputs", 32'({tick, clear_dist, period_req, overrun, moving}), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        wait_neg(5);
        reset = 1'b1;
        wait_neg(8);
        check("idle_outputs", 32'({tick, clear_dist, period_req, overrun, moving}), 32'd0);
        check("idle_state", 32'(fsm_state), 32'(STOPPED));

        start_rev(20, 8);
        check("first_moving", 32'(moving), 32'd1);
        check("first_state", 32'(fsm_state), 32'(FIRST));
        check("first_no_req", 32'(period_req), 32'd0);

        start_rev(60, 8);
        check("req_hold", 32'(period_req), 32'd1);
        check("period_hold", 32'(period), 32'd40);
        ack_pulse();
        check("req_acked", 32'(period_req), 32'd0);
        check("period_after_ack", 32'(period), 32'd40);
        check("no_overrun", 32'(overrun), 32'd0);

        for (int g = 0; g < 3; g++) begin
            reed = 1'b1;
            repeat (3) @(negedge clock);
            reed = 1'b0;
            repeat (5) @(negedge clock);
        end
        check("glitch_state", 32'(fsm_state), 32'(MOVING));
        check("glitch_moving", 32'(moving), 32'd1);

        start_rev(110, 8);
        check("acked_no_overrun", 32'(overrun), 32'd0);
        start_rev(150, 8);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_req", 32'(period_req), 32'd1);

        clear = 1'b1;
        @(negedge clock);
        check("clear_dist_pulse", 32'(clear_dist), 32'd1);
        check("overrun_cleared", 32'(overrun), 32'd0);
        check("clear_keeps_period", 32'(period), 32'd40);
        @(negedge clock);
        clear = 1'b0;
        check("clear_dist_one_cycle", 32'(clear_dist), 32'd0);
        check("clear_keeps_state", 32'(fsm_state), 32'(MOVING));

        wait_neg(150 + LAT + TO - 1);
        check("pre_timeout_moving", 32'(moving), 32'd1);
        check("pre_timeout_req", 32'(period_req), 32'd1);
        @(negedge clock);
        check("timeout_moving", 32'(moving), 32'd0);
        check("timeout_period", 32'(period), 32'd0);
        check("timeout_req", 32'(period_req), 32'd0);
        check("timeout_state", 32'(fsm_state), 32'(STOPPED));

        enable = 1'b0;
        start_rev(280, 8);
        check("paused_moving", 32'(moving), 32'd1);
        start_rev(320, 8);
        check("paused_period", 32'(period), 32'd40);
        ack_pulse();
        enable = 1'b1;

        start_rev(420, 8);
        check("edge_period_100", 32'(period), 32'd100);
        start_rev(521, 8);
        check("restart_state", 32'(fsm_state), 32'(FIRST));

        wait_neg(545);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reed_sequencer.md
# reed_sequencer

Front-end controller for the odometer datapath. Conditions the raw reed-switch input (synchronise, debounce, edge-detect) and issues exactly one `tick` per wheel revolution to the `distance` block. It measures the revolution period in clock cycles and hands it to the speed unit over a req/ack handshake. It also tracks moving/stopped state with a timeout and sequences trip clear and pause.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to change the filtered reed level (≥1).
- `PERIOD_W`, 16: width of the period counter and `period` output.
- `TIMEOUT`, 50000: cycles without a revolution before the state becomes stopped (2 ≤ TIMEOUT ≤ 2^PERIOD_W−1).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reed`  in  1  raw, asynchronous reed-switch contact.
- `enable`  in  1  1 = trip running; 0 = paused (ticks suppressed).
- `clear`  in  1  trip-clear request, level; acted on at rising edge.
- `tick`  out  1  one-cycle pulse per accepted revolution, to the `distance` block.
- `clear_dist`  out  1  one-cycle pulse that clears the `distance` accumulator.
- `period`  out  PERIOD_W  cycles between the last two revolution events.
- `period_req`  out  1  `period` holds a new, unconsumed value.
- `period_ack`  in  1  speed unit consumed `period`.
- `overrun`  out  1  sticky: a new period overwrote an unacked one; cleared by `clear`.
- `moving`  out  1  1 while not in STOPPED.

## Operation
- Synchroniser: two flops on `reed` give `reed_s`.
- Debounce: the filtered level `filt` toggles only after `reed_s` ≠ `filt` for DEBOUNCE_CYCLES consecutive cycles. The counter resets whenever `reed_s` == `filt`.
- Revolution event `ev`: the cycle in which `filt` rises 0→1. Falling edges produce no event.
- Period counter `cnt`: cleared to 0 on `ev`, otherwise increments each cycle, saturating at TIMEOUT. It is inactive (0) in STOPPED.
- FSM states and transitions:
  - STOPPED, on `ev` → FIRST (`cnt` cleared; no period produced).
  - FIRST, on `ev` → MOVING (period produced).
  - MOVING, on `ev` → MOVING (period produced).
  - FIRST or MOVING, when `cnt` reaches TIMEOUT−1 with no `ev` → STOPPED.
- `ev` and timeout in the same cycle: `ev` wins.
- Period produced: `period` ← `cnt`+1, `period_req` ← 1. If `period_req` was already 1 and `period_ack` is 0 that cycle, `overrun` ← 1.
- `period_req` clears on the cycle after `period_ack` is sampled high. `ack` and a new period in the same cycle: the new value is loaded, `req` stays 1, no overrun.
- Entering STOPPED: `period` ← 0, `period_req` ← 0. A pending unacked value is discarded.
- `tick` = registered (`ev` & `enable`). The FSM and period logic run regardless of `enable`.
- `clear` rising edge: `clear_dist` pulses one cycle and `overrun` ← 0. The FSM and `period` are unaffected.
- `moving` = (state ≠ STOPPED), registered.

## Timing
- All outputs reset to 0; state resets to STOPPED. The synchroniser, `filt` and all counters reset to 0.
- Reset is asynchronous assert, synchronous deassert as supplied by the top level. Reset mid-period discards the measurement, and the first `ev` after reset enters FIRST.
- Latency: edge 0 is the first rising edge sampling `reed`=1 with the input held stable. `tick` goes high at edge 2+DEBOUNCE_CYCLES and stays high exactly one cycle.
- The `clear_dist` pulse follows the `clear` rising edge by one cycle.
- `period` and `period_req` update at the same edge as `tick`.
- Minimum revolution spacing is 2·DEBOUNCE_CYCLES cycles. Shorter pulses are filtered and produce no event.

## Structure
- Shared package `bike_pkg`:
  - FSM state enum (STOPPED, FIRST, MOVING).
  - Default `PERIOD_W`, `TIMEOUT` and `DEBOUNCE_CYCLES` constants, also used by `distance` and the speed unit.
- Sub-module `reed_debounce`: synchroniser, debounce counter, `filt` and `ev` output.
- The top holds the FSM, period counter, handshake and clear logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT=100.
- Reset held low, then released with `reed`=0 → all outputs 0, `moving`=0, no `tick`.
- Clean `reed` pulse, 8 cycles high → exactly one `tick`, 6 edges after first high sample. `moving`=1, no `period_req`.
- Second clean pulse starting 40 cycles after the first → `period`=40, `period_req`=1. With `period_ack` held high 1 cycle → `period_req` drops next cycle.
- 3-cycle glitches on `reed` → no `tick`, no state change.
- Two revolutions 40 cycles apart with no ack → `overrun`=1. Then `clear` pulse → `clear_dist` one cycle, `overrun`=0, `period` unchanged.
- After a revolution, 100 cycles with no `reed` activity → `moving`=0, `period`=0, `period_req`=0. With `enable`=0 during a revolution → no `tick`, but `period` still updates.
